// File: rtl/rate_mult_seq_stage.sv
// rtl/rate_mult_seq_stage.sv - sequential stage around an 8-bit binary rate multiplier cone
//
// Holds the X counter, registers the Z pulse, loads the C rate word over a
// valid/ready handshake (applied only at frame wrap) and counts rate pulses per frame.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           count enable; counter and Z active only when high
//   rate_valid   new rate word offered
//   rate_ready   stage can accept a rate word (low while a shadow word is pending)
//   rate_data    C[WIDTH:0], bit 0 = C_0
//   x_state      current counter X, bit 0 = X_1
//   z_out        registered Z pulse, aligned to the X value before its increment
//   frame_done   one-cycle pulse when a frame has just completed
//   frame_count  rate pulses counted in the last completed frame
module rate_mult_seq_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             rate_valid,
  output logic             rate_ready,
  input  logic [WIDTH:0]   rate_data,
  output logic [WIDTH-1:0] x_state,
  output logic             z_out,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   c_act, c_shd;
  logic [WIDTH-1:0] x_q, x_inc;
  logic [CNT_W-1:0] acc, frame_count_q;
  logic             z_q, done_q;
  logic             active, hs, wrap;
  logic             c0_term, ck_term, z;
  logic [CNT_W-1:0] terms;

  assign active = (state_q != IDLE);
  assign hs     = rate_valid & rate_ready;
  assign wrap   = active & en & (&x_q);

  // Ripple toggle chain: X_k toggles when en and all lower bits are 1.
  always_comb begin
    logic carry;
    carry = en;
    x_inc = x_q;
    for (int i = 0; i < WIDTH; i++) begin
      x_inc[i] = x_q[i] ^ carry;
      carry    = carry & x_q[i];
    end
  end

  // C_k selected by the lowest set bit of X; X=0 selects nothing.
  always_comb begin
    logic found;
    found   = 1'b0;
    ck_term = 1'b0;
    for (int k = 1; k <= WIDTH; k++) begin
      if (!found && x_q[k-1]) begin
        ck_term = en & c_act[k];
        found   = 1'b1;
      end
    end
  end

  assign c0_term = en & c_act[0];
  assign z       = c0_term | ck_term;

  // The frame tally counts each contributing rate term separately, so a cycle
  // where both C_0 and C_k hit adds two; this gives 256*C_0 + sum C_k*2**(8-k).
  assign terms = {{(CNT_W-1){1'b0}}, c0_term} + {{(CNT_W-1){1'b0}}, ck_term};

  always_comb begin
    state_d    = state_q;
    rate_ready = 1'b1;
    case (state_q)
      IDLE: if (hs) state_d = RUN;
      RUN:  if (hs) state_d = PEND;
      PEND: begin
        rate_ready = 1'b0;
        if (wrap) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      c_act         <= '0;
      c_shd         <= '0;
      x_q           <= '0;
      acc           <= '0;
      frame_count_q <= '0;
      z_q           <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && hs) c_act <= rate_data;
      // A word accepted on the wrap edge itself only waits for the next wrap.
      if (state_q == RUN && hs) c_shd <= rate_data;
      if (state_q == PEND && wrap) c_act <= c_shd;
      if (active) begin
        x_q <= x_inc;
        z_q <= z;
        if (wrap) begin
          frame_count_q <= acc + terms;
          acc           <= '0;
          done_q        <= 1'b1;
        end else begin
          acc    <= acc + terms;
          done_q <= 1'b0;
        end
      end else begin
        z_q    <= 1'b0;
        done_q <= 1'b0;
      end
    end
  end

  assign x_state     = x_q;
  assign z_out       = z_q;
  assign frame_done  = done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_rate_mult_seq_stage.sv
// tb/tb_rate_mult_seq_stage.sv - directed bench for rate_mult_seq_stage
module tb_rate_mult_seq_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rate_valid;
  logic       rate_ready;
  logic [8:0] rate_data;
  logic [7:0] x_state;
  logic       z_out;
  logic       frame_done;
  logic [8:0] frame_count;

  int total = 0;
  int bad   = 0;

  rate_mult_seq_stage #(.WIDTH(8), .CNT_W(9)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rate_valid  (rate_valid),
    .rate_ready  (rate_ready),
    .rate_data   (rate_data),
    .x_state     (x_state),
    .z_out       (z_out),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // n ticks remain until the wrap edge; check the completed frame's count.
  task automatic run_to_wrap(input string tag, input int n, input logic [31:0] exp_cnt);
    ticks(n - 1);
    chk({tag, "_pre_done"}, frame_done, 0);
    tick();
    chk({tag, "_done"}, frame_done, 1);
    chk({tag, "_count"}, frame_count, exp_cnt);
    chk({tag, "_x0"}, x_state, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rate_valid = 1'b0; rate_data = '0;
    #12;
    chk("rst_x", x_state, 0);
    chk("rst_z", z_out, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cnt", frame_count, 0);
    chk("rst_ready", rate_ready, 1);
    rst_n = 1'b1;
    tick();
    chk("idle_hold_x", x_state, 0);

    // 1: C_0 only
    en = 1'b1; rate_valid = 1'b1; rate_data = 9'h001;
    tick();
    rate_valid = 1'b0;
    chk("t1_ready_run", rate_ready, 1);
    chk("t1_x_start", x_state, 0);
    tick();
    chk("t1_z", z_out, 1);
    chk("t1_x1", x_state, 1);
    run_to_wrap("t1", 255, 256);
    tick();
    chk("t1_done_clear", frame_done, 0);
    rate_valid = 1'b1; rate_data = 9'h002;
    tick();
    rate_valid = 1'b0;
    chk("t2_ready_pend", rate_ready, 0);
    run_to_wrap("t1b", 254, 256);
    chk("t2_ready_back", rate_ready, 1);

    // 2: C_1 -> z follows X_1 with one cycle lag
    tick();
    chk("t2_z_x0", z_out, 0);
    tick();
    chk("t2_z_x1", z_out, 1);
    tick();
    chk("t2_z_x2", z_out, 0);
    rate_valid = 1'b1; rate_data = 9'h100;
    tick();
    rate_valid = 1'b0;
    run_to_wrap("t2", 252, 128);

    // 3: C_8 -> single pulse for X=0x80
    ticks(8'h80);
    chk("t3_x80", x_state, 8'h80);
    chk("t3_z_before", z_out, 0);
    tick();
    chk("t3_z_pulse", z_out, 1);
    tick();
    chk("t3_z_after", z_out, 0);
    rate_valid = 1'b1; rate_data = 9'h1FF;
    tick();
    rate_valid = 1'b0;
    run_to_wrap("t3", 125, 1);
    run_to_wrap("t3_full", 256, 511);

    // 4: mid-frame offer, then a second valid stalled in PEND
    ticks(100);
    rate_valid = 1'b1; rate_data = 9'h004;
    tick();
    chk("t4_ready_low", rate_ready, 0);
    rate_data = 9'h002;
    ticks(20);
    chk("t4_stalled", rate_ready, 0);
    run_to_wrap("t4_old", 135, 511);
    chk("t4_ready_wrap", rate_ready, 1);
    tick();
    rate_valid = 1'b0;
    chk("t4_accept_wrap1", rate_ready, 0);
    run_to_wrap("t4_new", 255, 64);
    chk("t4_ready_run", rate_ready, 1);

    // simultaneous wrap and valid: shadow waits for the following wrap
    ticks(255);
    rate_valid = 1'b1; rate_data = 9'h001;
    tick();
    rate_valid = 1'b0;
    chk("sim_done", frame_done, 1);
    chk("sim_cnt", frame_count, 128);
    chk("sim_pend", rate_ready, 0);
    run_to_wrap("sim_next", 256, 128);

    // 5: en low for 10 cycles mid-frame, C_0 frame
    ticks(50);
    en = 1'b0;
    ticks(10);
    chk("t5_x_hold", x_state, 50);
    chk("t5_z_low", z_out, 0);
    en = 1'b1;
    run_to_wrap("t5", 206, 256);

    // 6: async reset mid-frame while PEND
    rate_valid = 1'b1; rate_data = 9'h002;
    tick();
    rate_valid = 1'b0;
    ticks(30);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_x", x_state, 0);
    chk("t6_z", z_out, 0);
    chk("t6_cnt", frame_count, 0);
    chk("t6_ready", rate_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(5);
    chk("t6_x_idle", x_state, 0);
    chk("t6_z_idle", z_out, 0);
    rate_valid = 1'b1; rate_data = 9'h002;
    tick();
    rate_valid = 1'b0;
    run_to_wrap("t6", 256, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
